mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Single-port memory controller for the five-stage pipeline: arbitrates instruction fetch (IF) and data access (MEM) onto one byte-wide synchronous RAM. It serialises each 32-bit access into byte transfers and assembles read bytes little-endian. It raises stall requests toward the pipeline control block while an access is outstanding. It sits between the IF/MEM stages and the top-level RAM port.

## Interface
- No parameters; address width 32, RAM data width 8.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset (`RstEnable`)
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  one-cycle pulse, if_inst valid
- if_inst  out  32  fetched word
- mem_req  in  1  data access request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  32  data byte address
- mem_size  in  2  00 byte, 01 half, 10/11 word
- mem_wdata  in  32  store data, low bytes used for sub-word
- mem_done  out  1  one-cycle pulse, access complete
- mem_rdata  out  32  load data, zero-extended; sign extension is done in MEM
- ram_addr  out  32  RAM byte address
- ram_wr  out  1  RAM write strobe
- ram_dout  out  8  RAM write byte
- ram_din  in  8  RAM read byte, valid one cycle after its address
- req_if  out  1  stall request from IF side (`Stop` when waiting)
- req_mem  out  1  stall request from MEM side

## Operation
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR.
- IDLE arbitration:
  - mem_req wins, because it belongs to the older instruction. It enters MEM_WR if mem_we, else MEM_RD.
  - Otherwise if_req enters IF_RD.
- Arbitration is non-preemptive: a request arriving during an access waits.
- On entry the block latches the base address, size, wdata and the byte count N, and clears counter cnt. Word N=4, half N=2, byte N=1.
- Reads: in the cycle with cnt=c (c<N), drive ram_addr=base+c. ram_din is captured into byte c at the edge ending cycle c+1. The state lasts N+1 cycles.
- Writes: in the cycle with cnt=c, drive ram_addr=base+c, ram_wr=1 and ram_dout=wdata byte c. The state lasts N cycles.
- Addresses are base+c modulo 2^32; wrap past 0xFFFFFFFF continues at 0.
- Completion:
  - done is registered and pulses for exactly 1 cycle; data outputs are valid in the same cycle.
  - The FSM is back in IDLE in that cycle, so the next access can start on the following edge.
- Outside access states: ram_wr=0, ram_addr=0, ram_dout=0.
- req_if = if_req & ~if_done; req_mem = mem_req & ~mem_done. Both are combinational.
- A request still high in the cycle after its done pulse is a new request.
- A request dropped mid-access still completes; the done pulse is ignored by the requester.
- Byte order is little-endian: byte c maps to bits [8c+7:8c]. Unread bytes of mem_rdata are 0.

## Timing
- Reset: state IDLE, cnt 0, and every output 0: if_done, mem_done, if_inst, mem_rdata, ram_addr, ram_wr, ram_dout. req_* still follow their equations.
- Reset mid-access aborts immediately: ram_wr is 0 from the next cycle and no done pulse is issued.
- Requests are sampled in IDLE in cycle T:
  - word read: ram addresses in T+1..T+4, done in T+6;
  - word write: writes in T+1..T+4, done in T+5;
  - byte write: write in T+1, done in T+2.
- Simultaneous if_req and mem_req in IDLE: MEM is served first. IF starts the cycle after mem_done at the earliest and req_if stays asserted throughout.

## Configuration
- MEM_CTRL_SUBWORD_EN defined:
  - loads read only N bytes by size (byte load: done in T+3);
  - IF and word loads are unchanged.
- Undefined:
  - every load reads 4 bytes (done in T+6);
  - mem_rdata is masked to mem_size, with upper bytes zero.
- Stores always write exactly N bytes in both builds.

## Structure
- defs.v holds:
  - state encodings `MemIdle`/`MemIfRd`/`MemRd`/`MemWr`;
  - size encodings `MemByte`/`MemHalf`/`MemWord`;
  - existing `Stop`/`RstEnable`.
- No sub-module; FSM, counter and byte assembly stay in one module.

## Test plan
- Word fetch: if_req=1, if_addr=0x100, RAM 0x100..0x103 = 13,00,00,00 -> ram_addr 0x100..0x103 in T+1..T+4; if_done in T+6 with if_inst=0x00000013; req_if=1 through T+5.
- Word store: mem_we=1, addr 0x200, wdata 0xDEADBEEF -> ram_wr in T+1..T+4 with bytes EF,BE,AD,DE at 0x200..0x203; mem_done in T+5.
- Byte load at 0x203 holding 0x80 -> mem_rdata 0x00000080. mem_done in T+3 with MEM_CTRL_SUBWORD_EN, T+6 without.
- Both requests in the same cycle, with a word load at 0x10 and a fetch at 0x0 -> the load completes first, then the fetch starts; if_done 6 cycles after mem_done.
- Wrap: word load at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
- rst asserted in T+2 of a word store -> no ram_wr from T+3, no mem_done, all outputs 0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the single-port memory controller: FSM state
// encodings, access-size encodings, pipeline control constants and small
// helpers that turn an access size into a byte count or a data mask.
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

   // Reset level and stall-request level shared with the pipeline control
   localparam logic RstEnable = 1'b1;
   localparam logic Stop      = 1'b1;

   // Controller states
   typedef enum logic [1:0] {
      MemIdle = 2'b00,
      MemIfRd = 2'b01,
      MemRd   = 2'b10,
      MemWr   = 2'b11
   } memState_e;

   // Access size encodings as driven by the MEM stage (2'b11 is also a word)
   localparam logic [1:0] MemByte = 2'b00;
   localparam logic [1:0] MemHalf = 2'b01;
   localparam logic [1:0] MemWord = 2'b10;

   // Number of byte transfers needed for an access of the given size
   function automatic logic [2:0] sizeBytes(input logic [1:0] size);
      case (size)
         MemByte: sizeBytes = 3'd1;
         MemHalf: sizeBytes = 3'd2;
         default: sizeBytes = 3'd4;
      endcase
   endfunction

   // Mask keeping only the bytes that belong to an access of the given size
   function automatic logic [31:0] sizeMask(input logic [1:0] size);
      case (size)
         MemByte: sizeMask = 32'h0000_00FF;
         MemHalf: sizeMask = 32'h0000_FFFF;
         default: sizeMask = 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
// Arbitrates instruction fetch (IF) and data access (MEM) onto one byte-wide
// synchronous RAM. Each 32-bit access is serialised into byte transfers and
// read bytes are assembled little-endian. MEM wins arbitration in IDLE; an
// access in progress is never preempted.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request and byte address
//   if_done/if_inst             one-cycle completion pulse and fetched word
//   mem_req/mem_we/mem_addr     data request, store flag, byte address
//   mem_size/mem_wdata          access size and store data
//   mem_done/mem_rdata          one-cycle completion pulse and load data
//   ram_addr/ram_wr/ram_dout    RAM address, write strobe, write byte
//   ram_din                     RAM read byte (one cycle after its address)
//   req_if/req_mem              stall requests toward pipeline control
//
// Build option MEM_CTRL_SUBWORD_EN: when defined, byte and half loads only
// read the bytes they need; otherwise every load reads a full word and the
// result is masked down to the requested size.
// ---------------------------------------------------------------------------
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_inst,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [1:0]  mem_size,
   input  logic [31:0] mem_wdata,
   output logic        mem_done,
   output logic [31:0] mem_rdata,
   output logic [31:0] ram_addr,
   output logic        ram_wr,
   output logic [7:0]  ram_dout,
   input  logic [7:0]  ram_din,
   output logic        req_if,
   output logic        req_mem
);

   memState_e   state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  n_q, n_d;
   logic [31:0] base_q, base_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] buf_q, buf_d;
   logic        ifDone_q, ifDone_d;
   logic        memDone_q, memDone_d;
   logic [31:0] ifInst_q, ifInst_d;
   logic [31:0] memRdata_q, memRdata_d;
   logic [5:0]  shift;

   // A requester whose done is pulsing this cycle is finishing, not asking
   // again, so its request is masked both as a stall and for arbitration.
   assign req_if  = (if_req  & ~ifDone_q)  ? Stop : ~Stop;
   assign req_mem = (mem_req & ~memDone_q) ? Stop : ~Stop;

   assign if_done   = ifDone_q;
   assign mem_done  = memDone_q;
   assign if_inst   = ifInst_q;
   assign mem_rdata = memRdata_q;

   // Next-state logic: arbitration in IDLE, byte sequencing in the access
   // states. Reads spend one extra cycle with cnt == N so the last RAM byte,
   // which arrives one cycle after its address, can be captured.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      n_d        = n_q;
      base_d     = base_q;
      size_d     = size_q;
      wdata_d    = wdata_q;
      buf_d      = buf_q;
      ifDone_d   = 1'b0;
      memDone_d  = 1'b0;
      ifInst_d   = ifInst_q;
      memRdata_d = memRdata_q;
      ram_addr   = 32'h0;
      ram_wr     = 1'b0;
      ram_dout   = 8'h0;
      shift      = {cnt_q - 3'd1, 3'b000};

      case (state_q)
         MemIdle: begin
            if (req_mem == Stop) begin
               base_d  = mem_addr;
               size_d  = mem_size;
               wdata_d = mem_wdata;
               cnt_d   = 3'd0;
               buf_d   = 32'h0;
               if (mem_we) begin
                  state_d = MemWr;
                  n_d     = sizeBytes(mem_size);
               end else begin
                  state_d = MemRd;
`ifdef MEM_CTRL_SUBWORD_EN
                  n_d     = sizeBytes(mem_size);
`else
                  n_d     = 3'd4;
`endif
               end
            end else if (req_if == Stop) begin
               state_d = MemIfRd;
               base_d  = if_addr;
               size_d  = MemWord;
               cnt_d   = 3'd0;
               n_d     = 3'd4;
               buf_d   = 32'h0;
            end
         end

         MemIfRd, MemRd: begin
            if (cnt_q < n_q) begin
               ram_addr = base_q + {29'b0, cnt_q};
            end
            if (cnt_q != 3'd0) begin
               buf_d = buf_q | (32'(ram_din) << shift);
            end
            if (cnt_q == n_q) begin
               state_d = MemIdle;
               cnt_d   = 3'd0;
               if (state_q == MemIfRd) begin
                  ifDone_d = 1'b1;
                  ifInst_d = buf_d;
               end else begin
                  memDone_d  = 1'b1;
                  memRdata_d = buf_d & sizeMask(size_q);
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end

         MemWr: begin
            ram_wr   = 1'b1;
            ram_addr = base_q + {29'b0, cnt_q};
            ram_dout = 8'(wdata_q >> {cnt_q, 3'b000});
            if (cnt_q == n_q - 3'd1) begin
               state_d   = MemIdle;
               cnt_d     = 3'd0;
               memDone_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end

         default: state_d = MemIdle;
      endcase
   end

   // State register; reset aborts any access without a done pulse
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state_q    <= MemIdle;
         cnt_q      <= 3'd0;
         n_q        <= 3'd0;
         base_q     <= 32'h0;
         size_q     <= MemByte;
         wdata_q    <= 32'h0;
         buf_q      <= 32'h0;
         ifDone_q   <= 1'b0;
         memDone_q  <= 1'b0;
         ifInst_q   <= 32'h0;
         memRdata_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         n_q        <= n_d;
         base_q     <= base_d;
         size_q     <= size_d;
         wdata_q    <= wdata_d;
         buf_q      <= buf_d;
         ifDone_q   <= ifDone_d;
         memDone_q  <= memDone_d;
         ifInst_q   <= ifInst_d;
         memRdata_q <= memRdata_d;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
// Self-checking bench for mem_ctrl. A byte-wide synchronous RAM is modelled
// here; a separate reference byte array tracks what memory should hold, and
// per-access cycle timing is predicted from the transfer count of each access.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_inst;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [1:0]  mem_size;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic [31:0] ram_addr;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;
   logic        req_if;
   logic        req_mem;

   logic [7:0]  ram   [0:4095];
   logic [7:0]  model [0:4095];
   int          checks = 0;
   int          errors = 0;

   mem_ctrl dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_size(mem_size), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout),
      .ram_din(ram_din), .req_if(req_if), .req_mem(req_mem)
   );

   // Clock generation
   always #5 clk = ~clk;

   // Synchronous byte RAM, low 12 address bits decoded
   always @(posedge clk) begin
      if (ram_wr) ram[ram_addr[11:0]] = ram_dout;
      ram_din <= ram[ram_addr[11:0]];
   end

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int nBytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [7:0] modelByte(input logic [31:0] a);
      return model[a[11:0]];
   endfunction

   // One complete access: request in cycle T, then check every cycle up to
   // the predicted done pulse against transfer count N.
   task automatic applyStimulus(input bit isIf, input bit we, input logic [31:0] addr,
                                input logic [1:0] size, input logic [31:0] wdata);
      int n, doneAt, dataBytes;
      logic [31:0] expData, expAddr, a, ws;
      logic        expWr;
      logic [7:0]  expDout;
      if (isIf) n = 4;
      else if (we) n = nBytes(size);
      else begin
`ifdef MEM_CTRL_SUBWORD_EN
         n = nBytes(size);
`else
         n = 4;
`endif
      end
      doneAt    = we ? n + 1 : n + 2;
      dataBytes = isIf ? 4 : nBytes(size);
      expData   = 32'h0;
      for (int i = 0; i < dataBytes; i++) begin
         a = addr + i;
         expData = expData | (32'(modelByte(a)) << (8 * i));
      end
      if (isIf) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_size = size; mem_wdata = wdata;
      end
      for (int k = 1; k <= doneAt; k++) begin
         tick();
         expWr   = we && (k <= n);
         expAddr = (k <= n) ? addr + 32'(k - 1) : 32'h0;
         ws      = wdata >> (8 * (k - 1));
         expDout = expWr ? ws[7:0] : 8'h0;
         checks++;
         if (ram_addr !== expAddr) begin
            errors++;
            $display("[TB] FAIL ram_addr cycle T+%0d: got %h expected %h", k, ram_addr, expAddr);
         end
         checks++;
         if (ram_wr !== expWr || ram_dout !== expDout) begin
            errors++;
            $display("[TB] FAIL ram_wr/dout cycle T+%0d: got %b/%h expected %b/%h", k, ram_wr, ram_dout, expWr, expDout);
         end
         checks++;
         if ((isIf ? if_done : mem_done) !== (k == doneAt) || (isIf ? mem_done : if_done) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done cycle T+%0d: got if=%b mem=%b expected %b on %s", k, if_done, mem_done, k == doneAt, isIf ? "if" : "mem");
         end
         checks++;
         if ((isIf ? req_if : req_mem) !== (k != doneAt)) begin
            errors++;
            $display("[TB] FAIL stall request cycle T+%0d: got %b expected %b", k, isIf ? req_if : req_mem, k != doneAt);
         end
      end
      if (!we) begin
         checks++;
         if ((isIf ? if_inst : mem_rdata) !== expData) begin
            errors++;
            $display("[TB] FAIL read data at %h: got %h expected %h", addr, isIf ? if_inst : mem_rdata, expData);
         end
      end else begin
         for (int i = 0; i < n; i++) begin
            a = addr + i;
            ws = wdata >> (8 * i);
            model[a[11:0]] = ws[7:0];
         end
      end
      if_req = 1'b0; mem_req = 1'b0;
      tick();
   endtask

   task automatic checkOutput(input string name);
      checks++;
      if ({if_done, mem_done, if_inst, mem_rdata, ram_addr, ram_wr, ram_dout} !== '0) begin
         errors++;
         $display("[TB] FAIL %s outputs: got done=%b/%b inst=%h rdata=%h addr=%h wr=%b dout=%h expected all 0",
                  name, if_done, mem_done, if_inst, mem_rdata, ram_addr, ram_wr, ram_dout);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req = 1'b1; if_addr = 32'h0;
      tick();
      checkOutput("reset");
      checks++;
      if (req_if !== 1'b1 || req_mem !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset req equations: got if=%b mem=%b expected 1/0", req_if, req_mem);
      end
      if_req = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      checkOutput("after reset");
   endtask

   task automatic test_directed();
      applyStimulus(1'b1, 1'b0, 32'h100, 2'b10, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h200, 2'b10, 32'hDEADBEEF);
      applyStimulus(1'b0, 1'b0, 32'h200, 2'b10, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h203, 2'b00, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h300, 2'b00, 32'h5A);
      applyStimulus(1'b0, 1'b1, 32'h304, 2'b01, 32'hFFFF1234);
      applyStimulus(1'b0, 1'b0, 32'h304, 2'b01, 32'h0);
   endtask

   task automatic test_wrap();
      applyStimulus(1'b0, 1'b0, 32'hFFFFFFFE, 2'b10, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'hFFFFFFFF, 2'b10, 32'h0);
   endtask

   // Both requests in one cycle: a word load at 0x10 is served first, then
   // the fetch at 0x0 starts the cycle after mem_done.
   task automatic test_arbitration();
      logic [31:0] expLoad, expInst, expAddr, a;
      expLoad = 32'h0; expInst = 32'h0;
      for (int i = 0; i < 4; i++) begin
         a = 32'h10 + i;
         expLoad = expLoad | (32'(modelByte(a)) << (8 * i));
         a = 32'h0 + i;
         expInst = expInst | (32'(modelByte(a)) << (8 * i));
      end
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10; mem_size = 2'b10;
      if_req = 1'b1; if_addr = 32'h0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k <= 4) expAddr = 32'h10 + 32'(k - 1);
         else if (k >= 7 && k <= 10) expAddr = 32'(k - 7);
         else expAddr = 32'h0;
         checks++;
         if (ram_addr !== expAddr || ram_wr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL arb ram_addr cycle T+%0d: got %h/%b expected %h/0", k, ram_addr, ram_wr, expAddr);
         end
         checks++;
         if (mem_done !== (k == 6) || if_done !== (k == 12) || req_if !== (k != 12)) begin
            errors++;
            $display("[TB] FAIL arb done/req cycle T+%0d: got mem=%b if=%b req_if=%b", k, mem_done, if_done, req_if);
         end
         if (k == 6) begin
            checks++;
            if (mem_rdata !== expLoad) begin
               errors++;
               $display("[TB] FAIL arb load data: got %h expected %h", mem_rdata, expLoad);
            end
            mem_req = 1'b0;
         end
      end
      checks++;
      if (if_inst !== expInst) begin
         errors++;
         $display("[TB] FAIL arb fetch data: got %h expected %h", if_inst, expInst);
      end
      if_req = 1'b0;
      tick();
   endtask

   // Reset during a word store: bytes 0 and 1 land, then everything stops
   task automatic test_reset_mid();
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h400; mem_size = 2'b10; mem_wdata = 32'hA1B2C3D4;
      tick();
      tick();
      rst = 1'b1; mem_req = 1'b0;
      model[12'h400] = 8'hD4;
      model[12'h401] = 8'hC3;
      tick();
      checkOutput("mid-access reset");
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         checkOutput("post-abort");
      end
      applyStimulus(1'b0, 1'b0, 32'h400, 2'b10, 32'h0);
   endtask

   task automatic test_random();
      bit          isIf, we;
      logic [1:0]  size;
      logic [31:0] addr;
      for (int i = 0; i < 30; i++) begin
         isIf = 1'($urandom_range(0, 1));
         we   = isIf ? 1'b0 : 1'($urandom_range(0, 1));
         size = 2'($urandom_range(0, 3));
         addr = (i % 5 == 0) ? 32'hFFFFF000 | 32'($urandom_range(0, 4095)) : 32'($urandom_range(0, 4095));
         applyStimulus(isIf, we, addr, size, $urandom);
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         model[i] = 8'($urandom);
         ram[i]   = model[i];
      end
      model[12'h100] = 8'h13; model[12'h101] = 8'h00; model[12'h102] = 8'h00; model[12'h103] = 8'h00;
      for (int i = 12'h100; i < 12'h104; i++) ram[i] = model[i];
      rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_we = 1'b0;
      mem_addr = 32'h0; mem_size = 2'b00; mem_wdata = 32'h0;
      test_reset();
      test_directed();
      model[12'h203] = 8'h80;
      ram[12'h203]   = 8'h80;
      applyStimulus(1'b0, 1'b0, 32'h203, 2'b00, 32'h0);
      test_wrap();
      test_arbitration();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
